// File: rtl/ncl_fa_sync_bridge.sv
// Clocked boundary for a dual-rail NCL full adder: encodes binary operands into DATA/NULL
// wavefronts and collects the dual-rail sum/carry back into a valid/ready result.
module ncl_fa_sync_bridge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       init,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic       op_a,
  input  logic       op_b,
  input  logic       op_cin,
  output logic [1:0] A,
  output logic [1:0] B,
  output logic [1:0] carryin,
  input  logic       ABCOMP,
  input  logic       carryinCOMP,
  input  logic [1:0] sum,
  output logic       sumCOMP,
  input  logic [1:0] carryout,
  output logic       carryCOMP,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_sum,
  output logic       res_cout,
  output logic       err_illegal,
  output logic       err_timeout
);
  localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {DrvIdle, DrvData, DrvNull} drv_e;
  typedef enum logic {ColWaitData, ColWaitNull} col_e;

  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic       ab_comp_s, ci_comp_s;
  logic [1:0] sum_s, cout_s;

  drv_e ab_q, ab_d, ci_q, ci_d;
  col_e s_st_q, s_st_d, c_st_q, c_st_d;
  logic [1:0] a_q, a_d, b_q, b_d, cin_q, cin_d;
  logic s_full_q, s_full_d, c_full_q, c_full_d;
  logic s_hold_q, s_hold_d, c_hold_q, c_hold_d;
  logic op_ready_q, op_ready_d, res_valid_q, res_valid_d;
  logic err_ill_q, err_ill_d, err_tmo_q, err_tmo_d;
  logic [3:0][CntW-1:0] tmo_q, tmo_d;
  logic [3:0] timed, changed;
  logic accept, hs, tmo_hit;

  assign ab_comp_s = sync_q[SYNC_STAGES-1][0];
  assign ci_comp_s = sync_q[SYNC_STAGES-1][1];
  assign sum_s     = sync_q[SYNC_STAGES-1][3:2];
  assign cout_s    = sync_q[SYNC_STAGES-1][5:4];

  assign accept = op_valid & op_ready_q;
  assign hs     = res_valid_q & res_ready;

  always_comb begin
    ab_d  = ab_q;
    ci_d  = ci_q;
    a_d   = a_q;
    b_d   = b_q;
    cin_d = cin_q;
    unique case (ab_q)
      DrvIdle: if (accept) begin
        ab_d = DrvData;
        a_d  = {op_a, ~op_a};
        b_d  = {op_b, ~op_b};
      end
      DrvData: if (ab_comp_s) begin
        ab_d = DrvNull;
        a_d  = 2'b00;
        b_d  = 2'b00;
      end
      DrvNull: if (!ab_comp_s) ab_d = DrvIdle;
      default: ab_d = DrvIdle;
    endcase
    unique case (ci_q)
      DrvIdle: if (accept) begin
        ci_d  = DrvData;
        cin_d = {op_cin, ~op_cin};
      end
      DrvData: if (ci_comp_s) begin
        ci_d  = DrvNull;
        cin_d = 2'b00;
      end
      DrvNull: if (!ci_comp_s) ci_d = DrvIdle;
      default: ci_d = DrvIdle;
    endcase
    // Look one flop ahead in the synchronizer so op_ready can itself be registered.
    op_ready_d = (ab_d == DrvIdle) && (ci_d == DrvIdle) &&
                 !sync_q[SYNC_STAGES-2][0] && !sync_q[SYNC_STAGES-2][1];
  end

  always_comb begin
    s_st_d   = s_st_q;
    c_st_d   = c_st_q;
    s_hold_d = s_hold_q;
    c_hold_d = c_hold_q;
    // A full channel cannot capture, so a handshake edge never coincides with a capture.
    s_full_d = s_full_q & ~hs;
    c_full_d = c_full_q & ~hs;
    unique case (s_st_q)
      ColWaitData: if (!s_full_q && (^sum_s)) begin
        s_hold_d = sum_s[1];
        s_full_d = 1'b1;
        s_st_d   = ColWaitNull;
      end
      ColWaitNull: if (sum_s == 2'b00) s_st_d = ColWaitData;
      default: s_st_d = ColWaitData;
    endcase
    unique case (c_st_q)
      ColWaitData: if (!c_full_q && (^cout_s)) begin
        c_hold_d = cout_s[1];
        c_full_d = 1'b1;
        c_st_d   = ColWaitNull;
      end
      ColWaitNull: if (cout_s == 2'b00) c_st_d = ColWaitData;
      default: c_st_d = ColWaitData;
    endcase
    res_valid_d = s_full_d & c_full_d;
    err_ill_d   = err_ill_q | (&sum_s) | (&cout_s);
  end

  always_comb begin
    timed   = {c_st_q == ColWaitNull, s_st_q == ColWaitNull, ci_q != DrvIdle, ab_q != DrvIdle};
    changed = {c_st_d != c_st_q, s_st_d != s_st_q, ci_d != ci_q, ab_d != ab_q};
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (changed[i]) begin
        tmo_d[i] = '0;
      end else if (timed[i] && tmo_q[i] != CntW'(TIMEOUT)) begin
        tmo_d[i] = tmo_q[i] + 1'b1;
      end
      if (timed[i] && tmo_q[i] == CntW'(TIMEOUT)) tmo_hit = 1'b1;
    end
    err_tmo_d = err_tmo_q | tmo_hit;
  end

  always_ff @(posedge clk) begin
    if (init) begin
      sync_q      <= '0;
      ab_q        <= DrvIdle;
      ci_q        <= DrvIdle;
      s_st_q      <= ColWaitData;
      c_st_q      <= ColWaitData;
      a_q         <= 2'b00;
      b_q         <= 2'b00;
      cin_q       <= 2'b00;
      s_full_q    <= 1'b0;
      c_full_q    <= 1'b0;
      s_hold_q    <= 1'b0;
      c_hold_q    <= 1'b0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      err_ill_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      tmo_q       <= '0;
    end else begin
      sync_q[0] <= {carryout, sum, carryinCOMP, ABCOMP};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      ab_q        <= ab_d;
      ci_q        <= ci_d;
      s_st_q      <= s_st_d;
      c_st_q      <= c_st_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      s_full_q    <= s_full_d;
      c_full_q    <= c_full_d;
      s_hold_q    <= s_hold_d;
      c_hold_q    <= c_hold_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      err_ill_q   <= err_ill_d;
      err_tmo_q   <= err_tmo_d;
      tmo_q       <= tmo_d;
    end
  end

  assign op_ready    = op_ready_q;
  assign A           = a_q;
  assign B           = b_q;
  assign carryin     = cin_q;
  assign sumCOMP     = (s_st_q == ColWaitNull);
  assign carryCOMP   = (c_st_q == ColWaitNull);
  assign res_valid   = res_valid_q;
  assign res_sum     = s_hold_q;
  assign res_cout    = c_hold_q;
  assign err_illegal = err_ill_q;
  assign err_timeout = err_tmo_q;

endmodule
